pipeline: RTL and testbench
===========================

Name: pipeline

Overview:
- Three-stage registered datapath that computes F = (A + B + C - D) * D on N-bit unsigned operands.
- Accepts a new operand set every clock cycle and delivers one result per cycle.
- Fixed 3-cycle latency.
- Used as a throughput-oriented arithmetic kernel. No handshake; the upstream block presents operands continuously.

Parameters:
- N, 10, width of every operand, of every intermediate register and of the result.

Ports:
- clk  input  1  rising-edge clock for all registers.
- rst_n  input  1  asynchronous, active-low reset.
- F  output  N  pipelined result (A + B + C - D) * D, modulo 2^N.
- A  input  N  operand.
- B  input  N  operand.
- C  input  N  operand.
- D  input  N  operand; used both as subtrahend and multiplier.
- out_valid  output  1  high when F holds a result computed from operands sampled after reset release.
- Positional declaration order is F, A, B, C, D, clk, rst_n, out_valid. Existing instantiations connect the first six ports by position.
- Interface (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Stage 1, on a clk rising edge:
  - s1_ab <= A + B
  - s1_cd <= C - D
  - s1_d <= D
- Stage 2:
  - s2_sum <= s1_ab + s1_cd
  - s2_d <= s1_d
- Stage 3:
  - F <= s2_sum * s2_d, keeping the low N bits of the product.
- Width rules:
  - Every add, subtract and multiply is truncated to N bits, i.e. mod 2^N.
  - C - D with D > C wraps in two's complement. The final result still equals the mathematical value mod 2^N.
  - No saturation and no overflow flag.
- Latency:
  - Operands sampled at rising edge k appear on F immediately after rising edge k+2.
  - That is three register stages; the output register is the third.
- Throughput: one result per cycle. Every stage updates every cycle; there are no stalls and no enables.
- Reset:
  - rst_n low asynchronously clears all stage registers, F and out_valid to 0, immediately and without waiting for a clock edge.
  - While rst_n stays low, all of these remain 0.
- Valid tracking:
  - A 3-bit shift register is loaded with 1s from rst_n-high edges; out_valid is its MSB.
  - out_valid rises after the third rising edge following reset release and then stays at 1.
- Reset mid-operation: in-flight results are discarded. F reads 0, and out_valid needs 3 fresh edges after release to return high.
- Combinational path from inputs to F: none. F is driven only by a register.
- X/Z inputs propagate with no special handling. The datapath carries no assertions.

Test Plan:
- Reset: hold rst_n = 0, toggle clk with any operands -> F = 0, out_valid = 0. Assert rst_n mid-stream -> F goes to 0 before the next clk edge.
- Streaming, N = 10: apply one operand set per cycle:
  - (A,B,C,D) = (0,0,0,0), expect F = 0
  - (1,2,3,4), expect F = 8
  - (0,3,5,2), expect F = 12
  - (1,0,1,1), expect F = 1
  - (2,2,2,2), expect F = 8
  - Each result appears exactly 2 edges after its sampling edge, with a new result every cycle.
- Latency/valid: release reset, then check out_valid = 0 after edges 1 and 2 and out_valid = 1 after edge 3. The first F matches the operands sampled at edge 1.
- Wrap-around: (A,B,C,D) = (0,0,0,1) -> F = 1023, i.e. (-1 * 1) mod 1024. Then (1023,1,0,0) -> F = 0.
- Multiply truncation: (A,B,C,D) = (0,0,100,50) -> (50 * 50) mod 1024 = 452. Then (1023,1023,1023,1023) -> ((2046) * 1023) mod 1024 = 2.
- Back-to-back hold: keep the same operands for 5 cycles -> F stays constant once filled, with no glitch between edges.

Source files
------------

// File: rtl/pipeline_if.sv
// Operand/result bundle for the pipeline kernel.
// master: drives operands a..d, observes result f and out_valid.
// slave : consumes operands, produces f and out_valid.
interface pipeline_if #(
    parameter int unsigned N = 10
);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] c;
    logic [N-1:0] d;
    logic [N-1:0] f;
    logic         out_valid;

    modport master (
        output a, b, c, d,
        input  f, out_valid
    );

    modport slave (
        input  a, b, c, d,
        output f, out_valid
    );
endinterface

// File: rtl/pipeline.sv
// Three-stage arithmetic kernel: F = (A + B + C - D) * D mod 2^N.
// One operand set accepted and one result produced per cycle; 3-cycle latency.
// Ports (positional order is fixed by existing instantiations):
//   F         result, driven only by the stage-3 register
//   A, B, C   operands
//   D         operand; subtrahend in stage 1 and multiplier in stage 3
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   out_valid high once F holds a result from operands sampled after reset release
module pipeline #(
    parameter int unsigned N = 10
) (
    output logic [N-1:0] F,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] C,
    input  logic [N-1:0] D,
    input  logic         clk,
    input  logic         rst_n,
    output logic         out_valid
);

    localparam int unsigned VLD_W = 3;

    logic [N-1:0]     s1_ab_q,  s1_ab_d;
    logic [N-1:0]     s1_cd_q,  s1_cd_d;
    logic [N-1:0]     s1_d_q,   s1_d_d;
    logic [N-1:0]     s2_sum_q, s2_sum_d;
    logic [N-1:0]     s2_d_q,   s2_d_d;
    logic [N-1:0]     f_q,      f_d;
    logic [VLD_W-1:0] vld_q,    vld_d;

    // Datapath next-state; every operation is N bits wide so results wrap mod 2^N.
    // C - D may wrap negative; the modular sum in stage 2 still yields the true value mod 2^N.
    always_comb begin
        s1_ab_d  = A + B;
        s1_cd_d  = C - D;
        s1_d_d   = D;
        s2_sum_d = s1_ab_q + s1_cd_q;
        s2_d_d   = s1_d_q;
        f_d      = s2_sum_q * s2_d_q;
    end

    // Valid tracker: shifts in a 1 per edge after release, saturating at all ones.
    always_comb begin
        vld_d = {vld_q[VLD_W-2:0], 1'b1};
    end

    // All stages update every cycle; reset discards in-flight data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_ab_q  <= '0;
            s1_cd_q  <= '0;
            s1_d_q   <= '0;
            s2_sum_q <= '0;
            s2_d_q   <= '0;
            f_q      <= '0;
            vld_q    <= '0;
        end else begin
            s1_ab_q  <= s1_ab_d;
            s1_cd_q  <= s1_cd_d;
            s1_d_q   <= s1_d_d;
            s2_sum_q <= s2_sum_d;
            s2_d_q   <= s2_d_d;
            f_q      <= f_d;
            vld_q    <= vld_d;
        end
    end

    assign F         = f_q;
    assign out_valid = vld_q[VLD_W-1];

endmodule

// File: tb/tb_pipeline.sv
// Self-checking bench for pipeline: directed spec vectors plus random stream
// compared against a plain-arithmetic reference with a 3-deep expectation queue.
module tb_pipeline;

    localparam int unsigned N    = 10;
    localparam int unsigned MASK = (1 << N) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    pipeline_if #(.N(N)) bus ();

    pipeline #(.N(N)) dut (
        .F         (bus.f),
        .A         (bus.a),
        .B         (bus.b),
        .C         (bus.c),
        .D         (bus.d),
        .clk       (clk),
        .rst_n     (rst_n),
        .out_valid (bus.out_valid)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int unsigned exp_q[$];
    int          edges_since_rel = 0;

    // Reference: 32-bit unsigned arithmetic wraps mod 2^32, masking gives mod 2^N.
    function automatic int unsigned f_model(int unsigned a, int unsigned b,
                                            int unsigned c, int unsigned d);
        int unsigned s;
        s = a + b + c - d;
        return (s * d) & MASK;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input int unsigned a, input int unsigned b,
                         input int unsigned c, input int unsigned d);
        bus.a = N'(a);
        bus.b = N'(b);
        bus.c = N'(c);
        bus.d = N'(d);
    endtask

    // One rising edge, then check F and out_valid 1 time unit later.
    task automatic tick(input string tag);
        int unsigned exp_f;
        @(posedge clk);
        if (rst_n) begin
            exp_q.push_back(f_model(32'(bus.a), 32'(bus.b), 32'(bus.c), 32'(bus.d)));
            if (exp_q.size() > 3) void'(exp_q.pop_front());
            edges_since_rel++;
        end
        #1;
        exp_f = (rst_n && exp_q.size() == 3) ? exp_q[0] : 0;
        check({tag, "_f"}, 32'(bus.f), 32'(exp_f));
        check({tag, "_valid"}, 32'(bus.out_valid), 32'((rst_n && edges_since_rel >= 3) ? 1 : 0));
    endtask

    // Assert reset between edges, check immediate clear, hold, release mid-cycle.
    task automatic do_reset(input int hold_edges);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_f", 32'(bus.f), 32'd0);
        check("rst_async_valid", 32'(bus.out_valid), 32'd0);
        exp_q.delete();
        edges_since_rel = 0;
        for (int i = 0; i < hold_edges; i++) begin
            drive($urandom_range(MASK), $urandom_range(MASK), $urandom_range(MASK), $urandom_range(MASK));
            tick("rst_hold");
        end
        #3;
        rst_n = 1'b1;
    endtask

    int unsigned dir_a[9] = '{0, 1, 0, 1, 2, 0, 1023,   0, 1023};
    int unsigned dir_b[9] = '{0, 2, 3, 0, 2, 0,    1,   0, 1023};
    int unsigned dir_c[9] = '{0, 3, 5, 1, 2, 0,    0, 100, 1023};
    int unsigned dir_d[9] = '{0, 4, 2, 1, 2, 1,    0,  50, 1023};
    int unsigned dir_f[9] = '{0, 8, 12, 1, 8, 1023, 0, 452, 2};

    initial begin
        logic [N-1:0] held_f;

        drive(0, 0, 0, 0);
        // Reset held low while clocking with arbitrary operands.
        #2;
        for (int i = 0; i < 3; i++) begin
            drive($urandom_range(MASK), $urandom_range(MASK), $urandom_range(MASK), $urandom_range(MASK));
            tick("pre_rst");
        end
        #3;
        rst_n = 1'b1;

        // Directed vectors streamed back to back, results checked against fixed values.
        for (int i = 0; i < 9 + 2; i++) begin
            if (i < 9) drive(dir_a[i], dir_b[i], dir_c[i], dir_d[i]);
            else       drive(0, 0, 0, 0);
            tick("dir");
            if (i >= 2) check($sformatf("dir_const%0d", i - 2), 32'(bus.f), 32'(dir_f[i-2]));
        end

        // Hold operands steady: F settles and does not change between edges.
        drive(17, 300, 5, 9);
        for (int i = 0; i < 5; i++) tick("hold");
        held_f = bus.f;
        check("hold_const", 32'(held_f), 32'(f_model(17, 300, 5, 9)));
        #3;
        check("hold_midcycle", 32'(bus.f), 32'(held_f));

        // Mid-stream reset discards in-flight results.
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            drive($urandom_range(MASK), $urandom_range(MASK), $urandom_range(MASK), $urandom_range(MASK));
            tick("post_rst");
        end

        // Random stream.
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(MASK), $urandom_range(MASK), $urandom_range(MASK), $urandom_range(MASK));
            tick("rand");
        end

        // Another reset, then stream again.
        do_reset(1);
        for (int i = 0; i < 50; i++) begin
            drive($urandom_range(MASK), $urandom_range(MASK), $urandom_range(MASK), $urandom_range(MASK));
            tick("rand2");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
